// File: rtl/store_sequencer.sv
// store_sequencer: sequences sw/sh/sb stores through the store-size merge datapath and the shared data memory.
//   Word stores write directly; halfword/byte stores do read -> wait -> latch MDR -> merge/write.
//   Optional feature macro: STORE_SEQ_ALIGN_CHECK_EN (rejects misaligned halfword/word stores).
//   Ports:
//     clk, reset (sync, active-low)
//     start, size[1:0], addr[31:0]  - request from main control (accepted only when idle)
//     busy, done, error             - handshake back to main control
//     mem_addr[31:0], mem_rd, mem_wr - shared data memory control
//     mdr_load, SSCtrl[1:0]          - MDR capture and store-size merge select
module store_sequencer #(
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mdr_load,
    output logic [1:0]  SSCtrl
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_LATCH, S_WRITE, S_DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0] size_q, size_d;
    logic err_q, err_d;
    logic reject;
    logic unused_lane_bits;
    // Lane bits travel with the request but are decoded by the datapath, not here.
    assign unused_lane_bits = ^addr_q[1:0];
`ifdef STORE_SEQ_ALIGN_CHECK_EN
    assign reject = (size == 2'b00) || (size == 2'b10 && addr[0]) || (size == 2'b01 && addr[1:0] != 2'b00);
`else
    assign reject = (size == 2'b00);
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d  = addr;
                size_d  = size;
                err_d   = reject;
                state_d = reject ? S_DONE : (size == 2'b01 ? S_WRITE : S_READ);
            end
            S_READ: begin
                // WAIT lasts exactly READ_LAT cycles: it exits when the counter reads zero.
                cnt_d   = CNT_W'(READ_LAT > 0 ? READ_LAT - 1 : 0);
                state_d = READ_LAT > 0 ? S_WAIT : S_LATCH;
            end
            S_WAIT: begin
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                state_d = cnt_q == '0 ? S_LATCH : S_WAIT;
            end
            S_LATCH: state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            err_q   <= err_d;
        end
    end
    assign busy     = state_q != S_IDLE;
    assign done     = state_q == S_DONE;
    assign error    = state_q == S_DONE && err_q;
    assign mem_addr = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_rd   = state_q == S_READ;
    assign mem_wr   = state_q == S_WRITE;
    assign mdr_load = state_q == S_LATCH;
    assign SSCtrl   = state_q == S_WRITE ? size_q : 2'b00;
endmodule

// File: tb/tb_store_sequencer.sv
// tb_store_sequencer: directed self-checking bench for store_sequencer at READ_LAT = 0, 1 and 3.
module tb_store_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0;
    logic        busy, done, error, mem_rd, mem_wr, mdr_load;
    logic [31:0] mem_addr;
    logic [1:0]  ssc;
    logic        busy0, done0, error0, mem_rd0, mem_wr0, mdr_load0;
    logic [31:0] mem_addr0;
    logic [1:0]  ssc0;
    logic        busy3, done3, error3, mem_rd3, mem_wr3, mdr_load3;
    logic [31:0] mem_addr3;
    logic [1:0]  ssc3;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_sequencer #(.READ_LAT(1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
        .busy(busy), .done(done), .error(error), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mdr_load(mdr_load), .SSCtrl(ssc));
    store_sequencer #(.READ_LAT(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
        .busy(busy0), .done(done0), .error(error0), .mem_addr(mem_addr0),
        .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mdr_load(mdr_load0), .SSCtrl(ssc0));
    store_sequencer #(.READ_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
        .busy(busy3), .done(done3), .error(error3), .mem_addr(mem_addr3),
        .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mdr_load(mdr_load3), .SSCtrl(ssc3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] s, input logic [31:0] a);
        start = 1'b1;
        size  = s;
        addr  = a;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n_done, n_rd, n_ssc, t0, t3;
        logic [1:0] ssc_w;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_strobes", {mem_rd, mem_wr, mdr_load, ssc, error}, 0);
        reset = 1'b1;
        tick();

        // word store
        req(2'b01, 32'h0000_0104);
        chk("w_wr", mem_wr, 1);
        chk("w_ssc", ssc, 2'b01);
        chk("w_addr", mem_addr, 32'h104);
        chk("w_rd_mdr", {mem_rd, mdr_load}, 0);
        chk("w_busy", busy, 1);
        tick();
        chk("w_done", {done, error}, 2'b10);
        chk("w_ctl_in_done", {mem_rd, mem_wr, mdr_load}, 0);
        tick();
        chk("w_idle", {busy, done}, 0);

        // byte store, READ_LAT=1
        req(2'b11, 32'h0000_0203);
        chk("b_c1_rd", {mem_rd, mem_wr, mdr_load}, 3'b100);
        chk("b_c1_addr", mem_addr, 32'h200);
        tick();
        chk("b_c2_wait", {mem_rd, mem_wr, mdr_load, busy}, 4'b0001);
        chk("b_c2_addr", mem_addr, 32'h200);
        tick();
        chk("b_c3_mdr", {mem_rd, mem_wr, mdr_load}, 3'b001);
        tick();
        chk("b_c4_wr", {mem_rd, mem_wr, mdr_load}, 3'b010);
        chk("b_c4_ssc", ssc, 2'b11);
        chk("b_c4_addr", mem_addr, 32'h200);
        tick();
        chk("b_c5_done", {done, error, ssc}, 4'b1000);
        tick();
        chk("b_idle", busy, 0);
        tick();
        tick();
        tick();

        // halfword store across READ_LAT = 0 and 3
        req(2'b10, 32'h0000_0042);
        t0 = 0;
        t3 = 0;
        n_ssc = 0;
        ssc_w = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            if (done0 && t0 == 0) t0 = k;
            if (done3 && t3 == 0) t3 = k;
            if (ssc0 != 2'b00) begin
                n_ssc++;
                ssc_w = mem_wr0 ? ssc0 : 2'b01;
            end
            tick();
        end
        chk("h_lat0_done_cycle", t0, 4);
        chk("h_lat3_done_cycle", t3, 7);
        chk("h_lat0_ssc_cycles", n_ssc, 1);
        chk("h_lat0_ssc_value", ssc_w, 2'b10);

        // illegal size
        req(2'b00, 32'h0000_0100);
        chk("ill_done", {done, error}, 2'b11);
        chk("ill_strobes", {mem_rd, mem_wr, mdr_load}, 0);
        tick();
        chk("ill_after", {done, error, busy}, 0);

        // start pulsed while busy is ignored
        req(2'b11, 32'h0000_0300);
        start = 1'b1;
        size  = 2'b01;
        addr  = 32'h0000_0500;
        tick();
        start = 1'b0;
        n_done = 0;
        chk("busy_ign_addr", mem_addr, 32'h300);
        for (int k = 0; k < 10; k++) begin
            if (done) n_done++;
            tick();
        end
        chk("busy_one_done", n_done, 1);
        chk("busy_idle", busy, 0);

        // reset during WAIT
        req(2'b11, 32'h0000_0400);
        tick();
        chk("r_in_wait", {busy, mem_rd, mem_wr}, 3'b100);
        reset = 1'b0;
        tick();
        chk("r_outs", {busy, done, error, mem_rd, mem_wr, mdr_load, ssc}, 0);
        chk("r_addr", mem_addr, 0);
        reset = 1'b1;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) n_done++;
            tick();
        end
        chk("r_no_done", n_done, 0);
        req(2'b01, 32'h0000_0008);
        chk("r_word_wr", mem_wr, 1);
        tick();
        chk("r_word_done", {done, error}, 2'b10);
        tick();

        // start with same-cycle reset: reset wins
        reset = 1'b0;
        req(2'b01, 32'h0000_0010);
        reset = 1'b1;
        chk("rs_lost", {busy, mem_wr}, 0);
        tick();

        // misaligned halfword
        req(2'b10, 32'h0000_0011);
`ifdef STORE_SEQ_ALIGN_CHECK_EN
        chk("al_reject", {done, error, mem_rd, mem_wr}, 4'b1100);
        tick();
`else
        chk("al_read", {mem_rd, done}, 2'b10);
        chk("al_addr", mem_addr, 32'h10);
        n_rd = 0;
        n_done = 0;
        for (int k = 2; k <= 6; k++) begin
            tick();
            if (done && !error) n_done = k;
            if (mem_rd) n_rd++;
        end
        chk("al_done_cycle", n_done, 5);
        chk("al_single_read", n_rd, 0);
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
